// File: rtl/keypad_display_ctrl_pkg.sv
// Shared types and constants for the keypad scanner / two-digit display controller.
// Holds the FSM state type, the key map and small column/row decode helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  // KEY_MAP[row][col]; row r is active when row_n[r]==0, col c when col_n[c]==0
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic is_single(input logic [NUM_COLS-1:0] v_n);
    int lows;
    lows = 0;
    for (int i = 0; i < NUM_COLS; i++) lows += int'(!v_n[i]);
    return (lows == 1);
  endfunction

  // Index of the (last) low bit of an active-low one-hot vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) if (!v_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_display_ctrl_if.sv
// Keypad pins and display-side outputs of the keypad controller.
// slave = the controller, master = whatever drives the keypad and consumes digits.
interface keypad_display_ctrl_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] col_n;
  logic [NUM_ROWS-1:0] row_n;
  logic [7:0]          digits;
  logic [3:0]          key_code;
  logic                key_valid;

  modport master (output col_n, input row_n, digits, key_code, key_valid);
  modport slave  (input col_n, output row_n, digits, key_code, key_valid);
endinterface

// File: rtl/keypad_display_ctrl_scan_tick_gen.sv
// Scan-rate divider: counts 0..SCAN_DIV-1 and flags the terminal count as a
// one-cycle tick, so the first tick lands SCAN_DIV cycles after reset release.
module scan_tick_gen #(
  parameter int SCAN_DIV = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            div <= '0;
    else if (div == LAST) div <= '0;
    else                  div <= div + W'(1);
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/keypad_display_ctrl.sv
// 4x4 keypad scanner with debounce; each accepted key shifts into a two-digit
// hex display register (right digit newest).
module keypad_display_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_display_ctrl_if.slave  kif
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  logic                tick;
  logic [NUM_COLS-1:0] col_meta, col_s;
  state_t              state;
  logic [CW-1:0]       cnt, cnt_inc;
  logic [NUM_ROWS-1:0] row_q;
  logic [NUM_COLS-1:0] lat_col;
  logic [3:0]          lat_code, cap_code, acc_code;
  logic                single, accept;
  logic [7:0]          digits_q;
  logic [3:0]          key_code_q;
  logic                key_valid_q;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Columns are asynchronous to clk; idle (released) value is all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= kif.col_n;
      col_s    <= col_meta;
    end
  end

  always_comb begin
    single   = is_single(col_s);
    cap_code = KEY_MAP[low_idx(row_q)][low_idx(col_s)];
    cnt_inc  = (cnt == CNT_DONE) ? cnt : cnt + CW'(1);
    accept   = 1'b0;
    acc_code = lat_code;
    if (tick) begin
      if (state == SCAN && single && DEBOUNCE_SCANS <= 1) begin
        accept   = 1'b1;
        acc_code = cap_code;
      end else if (state == DEBOUNCE && col_s == lat_col && cnt_inc == CNT_DONE) begin
        accept   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SCAN;
      cnt      <= '0;
      row_q    <= 4'b1110;
      lat_col  <= '1;
      lat_code <= '0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (single) begin
            lat_col  <= col_s;
            lat_code <= cap_code;
            if (accept) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              state <= DEBOUNCE;
              cnt   <= CW'(1);
            end
          end else begin
            row_q <= {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
          end
        end
        DEBOUNCE: begin
          // Row drive stays frozen, so a mismatch resumes scanning from this row.
          if (col_s != lat_col) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (accept) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt   <= cnt_inc;
          end
        end
        HELD: begin
          if (col_s != '1) begin
            cnt <= '0;
          end else if (cnt_inc == CNT_DONE) begin
            state <= SCAN;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q    <= 8'h00;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        digits_q   <= {digits_q[3:0], acc_code};
        key_code_q <= acc_code;
      end
    end
  end

  assign kif.row_n     = row_q;
  assign kif.digits    = digits_q;
  assign kif.key_code  = key_code_q;
  assign kif.key_valid = key_valid_q;

endmodule
